// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous memory (1-cycle read latency) between
//   the 6502 core bus (CPU) and a debug/loader port (DBG). A request is sampled
//   in IDLE. The winning port's command is registered and issued to memory for
//   exactly one cycle (ACC_*), together with a one-cycle grant pulse. Read data
//   is returned one cycle later with a one-cycle rvalid strobe.
//
//   Arbitration when both ports request:
//     default                : CPU has priority. A starvation counter forces a
//                              DBG win after STARVE_MAX consecutive CPU grants
//                              taken while DBG was waiting.
//     ARB_ROUND_ROBIN_EN     : (macro) winner alternates; the port that was not
//                              the last owner wins. No starvation counter.
//
// Ports
//   clk_i                  clock, all logic on the rising edge
//   reset_i                synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i   CPU command (held until cpu_gnt_o)
//   cpu_gnt_o              1-cycle pulse, CPU command issued to memory
//   cpu_rvalid_o/rdata_o   CPU read data strobe / data (data holds otherwise)
//   dbg_*                  same set for the debug/loader port
//   mem_en_o/we_o/addr_o/wdata_o    memory command (ena/wea/addra/dina)
//   mem_rdata_i            memory read data (douta)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC_CPU = 2'd1,
        ST_ACC_DBG = 2'd2
    } state_e;

    state_e              state_q;
    logic                cpu_gnt_q;
    logic                dbg_gnt_q;
    logic                cpu_rvalid_q;
    logic                dbg_rvalid_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dbg_rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                cpu_win;
    logic                dbg_win;

`ifdef ARB_ROUND_ROBIN_EN
    // 1: DBG owned the most recent grant, 0: CPU did
    logic                last_dbg_q;
`else
    localparam int                 CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]   STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
    logic [CNT_W-1:0]    starve_q;
`endif

    // Winner selection; only meaningful while IDLE, so at most one access
    // can start every two cycles and never both ports in the same cycle.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (state_q == ST_IDLE) begin
            if (cpu_req_i && dbg_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_dbg_q) begin
                    cpu_win = 1'b1;
                end else begin
                    dbg_win = 1'b1;
                end
`else
                if (starve_q == STARVE_LIM) begin
                    dbg_win = 1'b1;
                end else begin
                    cpu_win = 1'b1;
                end
`endif
            end else if (cpu_req_i) begin
                cpu_win = 1'b1;
            end else if (dbg_req_i) begin
                dbg_win = 1'b1;
            end else begin
                cpu_win = 1'b0;
            end
        end else begin
            cpu_win = 1'b0;
        end
    end

    // Access FSM, registered memory command, grant/rvalid strobes and
    // arbitration history.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= {DATA_W{1'b0}};
            dbg_rdata_q  <= {DATA_W{1'b0}};
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
`ifdef ARB_ROUND_ROBIN_EN
            last_dbg_q   <= 1'b1;
`else
            starve_q     <= CNT_ZERO;
`endif
        end else begin
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;

            // Keep the data that was just delivered so rdata holds afterwards.
            if (cpu_rvalid_q) begin
                cpu_rdata_q <= mem_rdata_i;
            end else begin
                cpu_rdata_q <= cpu_rdata_q;
            end
            if (dbg_rvalid_q) begin
                dbg_rdata_q <= mem_rdata_i;
            end else begin
                dbg_rdata_q <= dbg_rdata_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cpu_win) begin
                        state_q     <= ST_ACC_CPU;
                        cpu_gnt_q   <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= cpu_we_i;
                        mem_addr_q  <= cpu_addr_i;
                        mem_wdata_q <= cpu_wdata_i;
                    end else if (dbg_win) begin
                        state_q     <= ST_ACC_DBG;
                        dbg_gnt_q   <= 1'b1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= dbg_we_i;
                        mem_addr_q  <= dbg_addr_i;
                        mem_wdata_q <= dbg_wdata_i;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                // The memory samples the command at the end of ACC; reads
                // return data during the following cycle.
                ST_ACC_CPU: begin
                    state_q      <= ST_IDLE;
                    cpu_rvalid_q <= ~mem_we_q;
                end
                ST_ACC_DBG: begin
                    state_q      <= ST_IDLE;
                    dbg_rvalid_q <= ~mem_we_q;
                end
                default: begin
                    state_q      <= ST_IDLE;
                end
            endcase

`ifdef ARB_ROUND_ROBIN_EN
            if (cpu_win) begin
                last_dbg_q <= 1'b0;
            end else if (dbg_win) begin
                last_dbg_q <= 1'b1;
            end else begin
                last_dbg_q <= last_dbg_q;
            end
`else
            // Counts CPU grants taken while DBG waits; saturates at the limit.
            if (!dbg_req_i || dbg_win) begin
                starve_q <= CNT_ZERO;
            end else if (cpu_win && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + CNT_ONE;
            end else begin
                starve_q <= starve_q;
            end
`endif
        end
    end

    assign cpu_gnt_o    = cpu_gnt_q;
    assign dbg_gnt_o    = dbg_gnt_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

    // The memory already registers its read data, so in the rvalid cycle it is
    // forwarded directly; otherwise the last delivered value is presented.
    assign cpu_rdata_o  = cpu_rvalid_q ? mem_rdata_i : cpu_rdata_q;
    assign dbg_rdata_o  = dbg_rvalid_q ? mem_rdata_i : dbg_rdata_q;

endmodule
